dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between NUM_REQ requesters: core load/store unit on port 0, host/debug loader on port 1.
- Round-robin arbitration with a valid/ready request handshake and a valid/ready response handshake.
- Checks the address window and word alignment, then issues exactly one DMEM access per granted transaction.
- Sits between the requesters and the DMEM addr/wdata/memr/memw/rdata pins.

Parameters:
- NUM_REQ, 2, number of requesters; a value of 2 is the only one required to synthesise in this release.
- DMEM_BASE_ADDR, 32'h1000, byte address of DMEM word 0.
- DMEM_WORDS, 1024, DMEM depth in 32-bit words. The valid window is [BASE, BASE+4*DMEM_WORDS).

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero
- req_we  in  NUM_REQ  1 = store, 0 = load
- req_addr  in  NUM_REQ x 32  byte address
- req_wdata  in  NUM_REQ x 32  store data
- rsp_valid  out  NUM_REQ  response valid; one-hot or zero
- rsp_ready  in  NUM_REQ  requester accepts the response
- rsp_rdata  out  32  load data, shared by all requesters
- rsp_err  out  1  transaction rejected: out of window or misaligned
- mem_addr  out  32  to DMEM addr
- mem_wdata  out  32  to DMEM wdata
- mem_rd  out  1  to DMEM memr
- mem_wr  out  1  to DMEM memw
- mem_rdata  in  32  from DMEM rdata; combinational read

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (asynchronous):
  - state = IDLE; rr_ptr = 0.
  - All latched fields = 0: addr, wdata, we, id, err.
  - Outputs = 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_*.
- IDLE:
  - Winner = first asserted req_valid searching from rr_ptr upward, wrapping.
  - req_ready[winner] = 1 combinationally in the same cycle; no other ready bit is asserted.
  - On the handshake edge, latch addr, wdata, we and id.
  - err = (addr < BASE) OR (addr >= BASE+4*DMEM_WORDS) OR (addr[1:0] != 0).
  - rr_ptr = winner+1 mod NUM_REQ; go to ACCESS.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_rd = !we & !err; mem_wr = we & !err. The DMEM write commits on this cycle's rising edge.
  - At the end of the cycle: rsp_rdata <= (load & !err) ? mem_rdata : 0; rsp_err <= err. Go to RESP.
  - mem_rd and mem_wr are 0 in every other state; mem_addr and mem_wdata are 0 outside ACCESS.
- RESP:
  - rsp_valid[id] = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready[id]: go to IDLE.
  - rsp_ready on any other index is ignored.
  - req_ready = 0 throughout RESP, so there is no overlap.
- Latency and throughput:
  - Handshake at cycle N, DMEM access at N+1, rsp_valid from N+2.
  - Minimum 3 cycles per transaction.
- Stores return a response with rsp_rdata = 0. This is the store acknowledge.
- An erroneous transaction never asserts mem_rd or mem_wr.
- Requesters must hold req_* stable while valid and not ready. The arbiter does not rely on this after the handshake.
- Reset during ACCESS aborts the access: mem_wr drops asynchronously, and no write occurs if reset is asserted before the edge. A pending response is discarded.
- Address offset = (addr − BASE) >> 2 is computed in 32 bits. The DMEM does its own mapping; mem_addr carries the raw byte address.
- Fairness: two continuously requesting ports alternate strictly, so the worst-case wait is (NUM_REQ−1) transactions.

Decomposition:
- Package dmem_pkg:
  - DMEM_BASE_ADDR and DMEM_WORDS constants, shared with DMEM.
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t.
  - typedef struct dmem_req_t {we, addr, wdata}.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and found.
  - Kept separate so it can be reused by future bus arbiters.

Test Plan:
1. Reset, then port 0 stores 32'hDEAD_BEEF to 32'h1004; port 0 then loads from 32'h1004.
   - Store: mem_wr for 1 cycle with mem_addr = 32'h1004, rsp_valid[0] at N+2, rsp_err = 0.
   - Load: rsp_rdata = 32'hDEAD_BEEF.
2. Both ports hold valid loads continuously from reset.
   - Grants go 0,1,0,1; rsp_valid alternates [0],[1].
   - A new request is never accepted while in RESP.
3. Port 1 stores to 32'h0FFC, then to 32'h2000, then to 32'h1002.
   - All three get rsp_err = 1 and rsp_rdata = 0.
   - mem_wr never asserts.
4. Port 0 delays rsp_ready by 5 cycles while port 1 is valid.
   - rsp_valid[0] and rsp_rdata stay stable for 5 cycles; req_ready[1] = 0.
   - Port 1 is granted the cycle after the IDLE return.
5. Assert reset asynchronously mid-ACCESS of a store to 32'h1008.
   - All outputs go to 0 immediately; DMEM word 2 is unchanged.
   - The FSM restarts in IDLE with rr_ptr = 0.
6. Load from the last word, 32'h1FFC → accepted, rsp_err = 0. Load from 32'h2000 → rsp_err = 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the DMEM it fronts.
package dmem_pkg;

  // DMEM placement in the byte address space; the DMEM itself uses the same values.
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_1000;
  localparam int unsigned DMEM_WORDS     = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // True when a byte address lies outside [base, base + 4*words) or is not word aligned.
  // The upper bound is formed in 33 bits so a window ending at 4 GiB cannot wrap.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(words) << 2);
    return ({1'b0, addr} < {1'b0, base}) ||
           ({1'b0, addr} >= limit)       ||
           (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin priority picker: grants the first asserted request
// at or above ptr, wrapping back to index 0 when nothing above ptr is asking.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found
);

  logic [NUM_REQ-1:0] upper;
  logic               hit_upper;
  logic               hit_any;

  // Two-pass search: lowest request at or above ptr, else lowest request overall.
  always_comb begin
    upper     = '0;
    grant     = '0;
    hit_upper = 1'b0;
    hit_any   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      upper[i] = req[i] && (i >= 32'(ptr));
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (upper[i] && !hit_upper) begin
        grant[i]  = 1'b1;
        hit_upper = 1'b1;
      end
    end
    if (!hit_upper) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !hit_any) begin
          grant[i] = 1'b1;
          hit_any  = 1'b1;
        end
      end
    end
    found = |req;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between NUM_REQ requesters (port 0: core LSU,
// port 1: host/debug loader). Round-robin grant, one DMEM access per accepted
// request, window/alignment checking, and a held response until accepted.
module dmem_arbiter
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [31:0] DMEM_BASE_ADDR = dmem_pkg::DMEM_BASE_ADDR,
  parameter int unsigned DMEM_WORDS     = dmem_pkg::DMEM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic [31:0]           mem_rdata
);

  import dmem_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   lat_id;
  logic               lat_err;
  dmem_req_t          lat_req;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic [PTR_W-1:0]   win_id;
  logic [PTR_W-1:0]   next_ptr;
  dmem_req_t          win_req;
  logic [NUM_REQ-1:0] id_onehot;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .found (found)
  );

  // Winner index, its successor for the rotating pointer, and its request fields.
  always_comb begin
    win_id   = '0;
    next_ptr = '0;
    win_req  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id        = PTR_W'(i);
        next_ptr      = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
        win_req.we    = req_we[i];
        win_req.addr  = req_addr[i*32 +: 32];
        win_req.wdata = req_wdata[i*32 +: 32];
      end
    end
  end

  // One-hot form of the latched requester id, used to steer rsp_valid.
  always_comb begin
    id_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      id_onehot[i] = (32'(lat_id) == i);
    end
  end

  // Accept only in IDLE; gating with reset keeps ready low while reset is held.
  assign req_ready = ((state == IDLE) && !reset) ? grant : '0;

  // DMEM pins are decoded from registered state, so an asynchronous reset
  // drops mem_wr immediately and aborts a pending write.
  assign mem_addr  = (state == ACCESS) ? lat_req.addr  : '0;
  assign mem_wdata = (state == ACCESS) ? lat_req.wdata : '0;
  assign mem_rd    = (state == ACCESS) && !lat_req.we && !lat_err;
  assign mem_wr    = (state == ACCESS) &&  lat_req.we && !lat_err;

  // Arbitration FSM: latch a winner, perform one DMEM access, hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lat_req   <= '0;
      lat_id    <= '0;
      lat_err   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            lat_req <= win_req;
            lat_id  <= win_id;
            lat_err <= addr_err(win_req.addr, DMEM_BASE_ADDR, DMEM_WORDS);
            rr_ptr  <= next_ptr;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_rdata <= (!lat_req.we && !lat_err) ? mem_rdata : '0;
          rsp_err   <= lat_err;
          rsp_valid <= id_onehot;
          state     <= RESP;
        end
        RESP: begin
          // rsp_valid is one-hot on the owner, so this ignores other ready bits.
          if (|(rsp_ready & rsp_valid)) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
